// File: rtl/cbm2_keyboard.sv
// cbm2_keyboard - CBM-II keyboard matrix responder for the tpi2 scan port.
//
// Converts MiSTer ps2_key toggle events into a 16x6 pressed-key matrix and
// answers the TPI's active-low column scans with active-low row returns.
// Also keeps a latched shift-lock (caps key) and an all-keys-up control.
//
// Ports:
//   clk_sys     in   system clock
//   reset       in   synchronous, active-high reset
//   ps2_key     in   [10] toggle, [9] press, [8] E0-extended, [7:0] scancode
//   pa_in       in   column selects 0-7, active low
//   pb_in       in   column selects 8-15, active low
//   all_up      in   one-cycle pulse, releases every matrix key
//   pc_out      out  row returns, active low (registered)
//   shift_lock  out  shift-lock latch state
//   overflow    out  sticky, an event was dropped
//   busy        out  FSM not idle or pending slot occupied
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an event (new or pending)
// LOOKUP | registered keymap read of the current event word
// APPLY  | write matrix / toggle shift-lock, then IDLE or next LOOKUP

module cbm2_keyboard (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  pa_in,
  input  logic [7:0]  pb_in,
  input  logic        all_up,
  output logic [5:0]  pc_out,
  output logic        shift_lock,
  output logic        overflow,
  output logic        busy
);

  localparam int MAP_ROWS = 6;
  localparam int MAP_COLS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    APPLY  = 2'd2
  } state_t;

  state_t                            state_q;
  logic                              last_toggle_q;
  logic                              pend_full_q;
  logic [9:0]                        pend_word_q;
  logic [9:0]                        cur_word_q;
  logic [8:0]                        map_q;
  logic [MAP_COLS-1:0][MAP_ROWS-1:0] matrix_q;
  logic                              shift_lock_q;
  logic                              overflow_q;
  logic [MAP_ROWS-1:0]               pc_out_q;

  logic                              evt;
  logic [8:0]                        map_d;
  logic [MAP_ROWS-1:0]               hits_d;
  logic [MAP_COLS-1:0]               sel;

  // Fields of the registered keymap entry
  logic                              map_valid;
  logic [3:0]                        map_col;
  logic [2:0]                        map_row;
  logic                              map_lock;

  assign evt = (ps2_key[10] != last_toggle_q);

  assign map_valid = map_q[8];
  assign map_col   = map_q[7:4];
  assign map_row   = map_q[3:1];
  assign map_lock  = map_q[0];

  // Keymap: {valid, col[3:0], row[2:0], is_lock} for the current event word.
  // The extended flag must match exactly, so E0-prefixed aliases stay invalid.
  always_comb begin
    map_d = 9'h000;
    if (!cur_word_q[8]) begin
      case (cur_word_q[7:0])
        8'h1C:       map_d = {1'b1, 4'd2,  3'd1, 1'b0};
        8'h29:       map_d = {1'b1, 4'd15, 3'd2, 1'b0};
        8'h12, 8'h59: map_d = {1'b1, 4'd0,  3'd4, 1'b0};
        8'h58:       map_d = {1'b1, 4'd0,  3'd0, 1'b1};
        default:     map_d = 9'h000;
      endcase
    end else begin
      case (cur_word_q[7:0])
        8'h75:       map_d = {1'b1, 4'd14, 3'd3, 1'b0};
        default:     map_d = 9'h000;
      endcase
    end
  end

  // Scan: shift-lock shows up as col 1 row 4 without touching the stored bit.
  assign sel = ~{pb_in, pa_in};

  always_comb begin
    hits_d = '0;
    for (int c = 0; c < MAP_COLS; c++) begin
      logic [MAP_ROWS-1:0] eff;
      eff = matrix_q[c];
      if (c == 1) eff[4] = eff[4] | shift_lock_q;
      if (sel[c]) hits_d = hits_d | eff;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      last_toggle_q <= ps2_key[10];
      pend_full_q   <= 1'b0;
      pend_word_q   <= '0;
      cur_word_q    <= '0;
      map_q         <= '0;
      matrix_q      <= '0;
      shift_lock_q  <= 1'b0;
      overflow_q    <= 1'b0;
      pc_out_q      <= '1;
    end else begin
      pc_out_q <= ~hits_d;

      if (evt) last_toggle_q <= ps2_key[10];

      // An event that the idle FSM cannot take directly goes to the slot,
      // or is lost if the slot is already occupied.
      if (evt && pend_full_q) begin
        overflow_q <= 1'b1;
      end else if (evt && state_q != IDLE) begin
        pend_word_q <= ps2_key[9:0];
        pend_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (pend_full_q) begin
            cur_word_q  <= pend_word_q;
            pend_full_q <= 1'b0;
            state_q     <= LOOKUP;
          end else if (evt) begin
            cur_word_q <= ps2_key[9:0];
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          map_q   <= map_d;
          state_q <= APPLY;
        end
        APPLY: begin
          if (map_valid && map_lock && cur_word_q[9])
            shift_lock_q <= ~shift_lock_q;
          if (pend_full_q) begin
            cur_word_q  <= pend_word_q;
            pend_full_q <= 1'b0;
            state_q     <= LOOKUP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // all_up takes priority over a same-cycle matrix write.
      if (all_up)
        matrix_q <= '0;
      else if (state_q == APPLY && map_valid && !map_lock)
        matrix_q[map_col][map_row] <= cur_word_q[9];
    end
  end

  assign pc_out     = pc_out_q;
  assign shift_lock = shift_lock_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) || pend_full_q;

endmodule
